// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm game lane logic: judgement codes,
// chart word layout, note type encodings and the lane FSM state set.
package rhythm_pkg;

  // Judgement code carried on judge_result; NONE means "no judgement this cycle".
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PERFECT = 2'd1,
    GOOD    = 2'd2,
    MISS    = 2'd3
  } judge_t;

  // Lane FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Chart word layout: [15:14] note type, [13:0] frame time.
  localparam int NOTE_TIME_W   = 14;
  localparam int NOTE_TYPE_MSB = 15;
  localparam int NOTE_TYPE_LSB = 14;

  // Note type encodings; 2'b11 is reserved and played as a TAP.
  localparam logic [1:0] NOTE_TAP        = 2'b00;
  localparam logic [1:0] NOTE_HOLD_START = 2'b01;
  localparam logic [1:0] NOTE_HOLD_END   = 2'b10;

  // Saturating increment for the 10-bit combo and statistics counters.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/judge_window.sv
// Timing window classifier: compares the song frame count against a note's
// frame time and reports the in-window judgement plus late/early/reached flags.
module judge_window
  import rhythm_pkg::*;
#(
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6
) (
  input  logic [NOTE_TIME_W-1:0] song_time,
  input  logic [NOTE_TIME_W-1:0] note_time,
  output judge_t                 hit,
  output logic                   late,
  output logic                   early,
  output logic                   reached
);

  localparam logic signed [NOTE_TIME_W:0] GOOD_S    = (NOTE_TIME_W+1)'(GOOD_WIN);
  localparam logic        [NOTE_TIME_W:0] PERFECT_U = (NOTE_TIME_W+1)'(PERFECT_WIN);
  localparam logic        [NOTE_TIME_W:0] GOOD_U    = (NOTE_TIME_W+1)'(GOOD_WIN);

  logic signed [NOTE_TIME_W:0] diff;
  logic        [NOTE_TIME_W:0] mag;

  // Signed distance from the note (positive = player is late) and its magnitude.
  always_comb begin
    diff = signed'({1'b0, song_time} - {1'b0, note_time});
    mag  = diff[NOTE_TIME_W] ? unsigned'(-diff) : unsigned'(diff);
  end

  // Classify the distance into a judgement and the out-of-window flags.
  always_comb begin
    hit = NONE;
    if (mag <= PERFECT_U) begin
      hit = PERFECT;
    end else if (mag <= GOOD_U) begin
      hit = GOOD;
    end
    late    = (diff > GOOD_S);
    early   = (diff < -GOOD_S);
    reached = ~diff[NOTE_TIME_W];
  end

endmodule

// File: rtl/lane_judge.sv
// Per-lane judgement engine. Walks the lane chart ROM, judges each note against
// the song frame count and the lane key, and reports judgements, hold status
// and the running combo.
// Optional build macro LANE_JUDGE_STATS_EN adds n_perfect/n_good/n_miss and
// max_combo statistics outputs; without it those ports do not exist.
//
// Output protocol: judge_valid is a single-cycle pulse with no backpressure;
// judge_result is meaningful in that cycle and holds its value afterwards.
module lane_judge
  import rhythm_pkg::*;
#(
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6,
  parameter int NUM_NOTES   = 128,
  parameter int ADDR_W      = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [NOTE_TIME_W-1:0] song_time,
  input  logic                   key_down,
  input  logic [15:0]            note_word,
  output logic [ADDR_W-1:0]      addr,
  output logic                   judge_valid,
  output logic [1:0]             judge_result,
  output logic                   hold_active,
  output logic [9:0]             combo,
  output logic                   done,
`ifdef LANE_JUDGE_STATS_EN
  output logic [9:0]             n_perfect,
  output logic [9:0]             n_good,
  output logic [9:0]             n_miss,
  output logic [9:0]             max_combo,
`endif
  output state_t                 dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NOTES);

  state_t            state, state_n;
  logic              key_q;
  logic [ADDR_W-1:0] addr_n;
  logic [9:0]        combo_n;
  logic              jv_n;
  logic [1:0]        jr_n;
  logic              hold_n;
  logic              done_n;
  judge_t            evt;

  logic [1:0]             note_type;
  logic [NOTE_TIME_W-1:0] note_time;
  logic                   press;
  judge_t                 hit;
  logic                   late;
  logic                   early;
  logic                   reached;

`ifdef LANE_JUDGE_STATS_EN
  logic [9:0] n_perfect_n, n_good_n, n_miss_n, max_combo_n;
`endif

  assign note_type = note_word[NOTE_TYPE_MSB:NOTE_TYPE_LSB];
  assign note_time = note_word[NOTE_TIME_W-1:0];
  assign press     = key_down & ~key_q;
  assign dbg_state = state;

  judge_window #(
    .PERFECT_WIN(PERFECT_WIN),
    .GOOD_WIN   (GOOD_WIN)
  ) u_window (
    .song_time(song_time),
    .note_time(note_time),
    .hit      (hit),
    .late     (late),
    .early    (early),
    .reached  (reached)
  );

  // Previous key level, used for press edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_down;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      addr         <= '0;
      combo        <= '0;
      judge_valid  <= 1'b0;
      judge_result <= 2'd0;
      hold_active  <= 1'b0;
      done         <= 1'b0;
`ifdef LANE_JUDGE_STATS_EN
      n_perfect    <= '0;
      n_good       <= '0;
      n_miss       <= '0;
      max_combo    <= '0;
`endif
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      combo        <= combo_n;
      judge_valid  <= jv_n;
      judge_result <= jr_n;
      hold_active  <= hold_n;
      done         <= done_n;
`ifdef LANE_JUDGE_STATS_EN
      n_perfect    <= n_perfect_n;
      n_good       <= n_good_n;
      n_miss       <= n_miss_n;
      max_combo    <= max_combo_n;
`endif
    end
  end

  // Next-state, judgement event selection and output updates.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    combo_n = combo;
    jv_n    = 1'b0;
    jr_n    = judge_result;
    hold_n  = hold_active;
    done_n  = done;
    evt     = NONE;
`ifdef LANE_JUDGE_STATS_EN
    n_perfect_n = n_perfect;
    n_good_n    = n_good;
    n_miss_n    = n_miss;
    max_combo_n = max_combo;
`endif

    if (start) begin
      // A restart overrides anything the head note would have produced.
      state_n = RUN;
      addr_n  = '0;
      combo_n = '0;
      done_n  = 1'b0;
      hold_n  = 1'b0;
`ifdef LANE_JUDGE_STATS_EN
      n_perfect_n = '0;
      n_good_n    = '0;
      n_miss_n    = '0;
      max_combo_n = '0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (addr == LAST_ADDR) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else if (note_type == NOTE_HOLD_END) begin
            // Orphaned hold end: only the window expiry can retire it.
            if (late) begin
              evt = MISS;
            end
          end else begin
            // TAP, HOLD_START and reserved types are played as a hit.
            if (press && (hit != NONE)) begin
              evt = hit;
              if (note_type == NOTE_HOLD_START) begin
                state_n = HOLD;
                hold_n  = 1'b1;
              end
            end else if (late) begin
              evt = MISS;
            end
          end
        end
        HOLD: begin
          if (addr == LAST_ADDR) begin
            // Chart ended on a hold start; nothing left to close it.
            state_n = RUN;
            hold_n  = 1'b0;
          end else begin
            if (!key_down) begin
              // Let go: in-window release is graded, anything else misses.
              evt = (hit != NONE) ? hit : MISS;
            end else if (reached) begin
              evt = PERFECT;
            end
            if (evt != NONE) begin
              state_n = RUN;
              hold_n  = 1'b0;
            end
          end
        end
        default: begin
          // IDLE and DONE keep every output as it is.
        end
      endcase
    end

    if (evt != NONE) begin
      jv_n   = 1'b1;
      jr_n   = evt;
      addr_n = addr + ADDR_W'(1);
      if (evt == MISS) begin
        combo_n = '0;
      end else begin
        combo_n = sat_inc10(combo);
      end
`ifdef LANE_JUDGE_STATS_EN
      case (evt)
        PERFECT: n_perfect_n = sat_inc10(n_perfect);
        GOOD:    n_good_n    = sat_inc10(n_good);
        default: n_miss_n    = sat_inc10(n_miss);
      endcase
      if (combo_n > max_combo) begin
        max_combo_n = combo_n;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lane_judge.sv
// Directed bench for lane_judge: a per-cycle vector table driven through a
// small chart ROM model, plus a hand-written mid-hold reset sequence.
module tb_lane_judge;
  import rhythm_pkg::*;

  localparam int NN = 4;

  // Clock / reset
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic        start = 1'b0;
  logic [13:0] song_time = '0;
  logic        key_down = 1'b0;
  logic [15:0] note_word;
  logic [7:0]  addr;
  logic        judge_valid;
  logic [1:0]  judge_result;
  logic        hold_active;
  logic [9:0]  combo;
  logic        done;
  state_t      dbg_state;
  int          rom_sel = 0;

  lane_judge #(
    .PERFECT_WIN(3),
    .GOOD_WIN   (6),
    .NUM_NOTES  (NN),
    .ADDR_W     (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .song_time   (song_time),
    .key_down    (key_down),
    .note_word   (note_word),
    .addr        (addr),
    .judge_valid (judge_valid),
    .judge_result(judge_result),
    .hold_active (hold_active),
    .combo       (combo),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // Chart ROM model: three songs of four notes each.
  function automatic logic [15:0] rom_word(input int sel, input logic [7:0] a);
    logic [15:0] w;
    w = 16'h0000;
    case (sel)
      0: case (a)
           8'd0: w = {2'b00, 14'd50};
           8'd1: w = {2'b00, 14'd83};
           8'd2: w = {2'b00, 14'd200};
           8'd3: w = {2'b00, 14'd300};
           default: w = 16'h0000;
         endcase
      1: case (a)
           8'd0: w = {2'b01, 14'd2059};
           8'd1: w = {2'b10, 14'd2077};
           8'd2: w = {2'b00, 14'd3000};
           8'd3: w = {2'b00, 14'd3001};
           default: w = 16'h0000;
         endcase
      default: case (a)
           8'd0: w = {2'b00, 14'd10};
           8'd1: w = {2'b00, 14'd20};
           8'd2: w = {2'b00, 14'd30};
           8'd3: w = {2'b00, 14'd40};
           default: w = 16'h0000;
         endcase
    endcase
    return w;
  endfunction

  always_comb note_word = rom_word(rom_sel, addr);

  // Vector table
  typedef struct {
    string       name;
    int          rom;
    bit          start;
    logic [13:0] st;
    bit          key;
    bit          v;
    logic [1:0]  r;
    logic [7:0]  a;
    logic [9:0]  c;
    bit          h;
    bit          d;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input string n, input int rom, input bit s,
                              input int st, input bit k, input bit v, input int r,
                              input int a, input int c, input bit h, input bit d);
    vec_t x;
    x.name = n; x.rom = rom; x.start = s; x.st = 14'(st); x.key = k;
    x.v = v; x.r = 2'(r); x.a = 8'(a); x.c = 10'(c); x.h = h; x.d = d;
    vt.push_back(x);
  endfunction

  // Scoreboard
  logic [22:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [22:0] pack_exp(input bit v, input logic [1:0] r,
                                           input logic [7:0] a, input logic [9:0] c,
                                           input bit h, input bit d);
    return {v, r, a, c, h, d};
  endfunction

  task automatic compare(input string name);
    logic [22:0] exp;
    logic [22:0] got;
    exp = exp_q.pop_front();
    got = {judge_valid, judge_result, addr, combo, hold_active, done};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%0b r=%0d addr=%0d combo=%0d hold=%0b done=%0b, want v=%0b r=%0d addr=%0d combo=%0d hold=%0b done=%0b",
               name, got[22], got[21:20], got[19:12], got[11:2], got[1], got[0],
               exp[22], exp[21:20], exp[19:12], exp[11:2], exp[1], exp[0]);
    end
  endtask

  // Driver: inputs change on the falling edge, outputs sampled just after the rising edge.
  task automatic apply(input vec_t x);
    @(negedge Clk);
    rom_sel   = x.rom;
    start     = x.start;
    song_time = x.st;
    key_down  = x.key;
    exp_q.push_back(pack_exp(x.v, x.r, x.a, x.c, x.h, x.d));
    @(posedge Clk);
    #1;
    compare(x.name);
  endtask

  initial begin
    //   name            rom s  st    k  v  r  a  c  h  d
    add("a_start",        0, 1, 0,    0, 0, 0, 0, 0, 0, 0);
    add("a_perfect_p1",   0, 0, 51,   1, 1, 1, 1, 1, 0, 0);
    add("a_quiet",        0, 0, 52,   0, 0, 1, 1, 1, 0, 0);
    add("a_edge_p6",      0, 0, 89,   0, 0, 1, 1, 1, 0, 0);
    add("a_miss_p7",      0, 0, 90,   0, 1, 3, 2, 0, 0, 0);
    add("b_start",        0, 1, 0,    0, 0, 3, 0, 0, 0, 0);
    add("b_early_ign",    0, 0, 40,   1, 0, 3, 0, 0, 0, 0);
    add("b_release",      0, 0, 41,   0, 0, 3, 0, 0, 0, 0);
    add("b_good_m4",      0, 0, 46,   1, 1, 2, 1, 1, 0, 0);
    add("b_release2",     0, 0, 47,   0, 0, 2, 1, 1, 0, 0);
    add("b_good_p6",      0, 0, 89,   1, 1, 2, 2, 2, 0, 0);
    add("c_start",        0, 1, 0,    0, 0, 2, 0, 0, 0, 0);
    add("c_good_p5",      0, 0, 55,   1, 1, 2, 1, 1, 0, 0);
    add("c_release",      0, 0, 56,   0, 0, 2, 1, 1, 0, 0);
    add("c_late_press",   0, 0, 90,   1, 1, 3, 2, 0, 0, 0);
    add("s_start_press",  0, 1, 51,   1, 0, 3, 0, 0, 0, 0);
    add("s_no_edge",      0, 0, 52,   1, 0, 3, 0, 0, 0, 0);
    add("s_release",      0, 0, 53,   0, 0, 3, 0, 0, 0, 0);
    add("s_perfect_p3",   0, 0, 53,   1, 1, 1, 1, 1, 0, 0);
    add("h_start",        1, 1, 0,    0, 0, 1, 0, 0, 0, 0);
    add("h_press",        1, 0, 2060, 1, 1, 1, 1, 1, 1, 0);
    add("h_held",         1, 0, 2061, 1, 0, 1, 1, 1, 1, 0);
    add("h_held_m1",      1, 0, 2076, 1, 0, 1, 1, 1, 1, 0);
    add("h_end_reached",  1, 0, 2077, 1, 1, 1, 2, 2, 0, 0);
    add("h_release_run",  1, 0, 2078, 0, 0, 1, 2, 2, 0, 0);
    add("r_start",        1, 1, 0,    0, 0, 1, 0, 0, 0, 0);
    add("r_press",        1, 0, 2060, 1, 1, 1, 1, 1, 1, 0);
    add("r_early_rel",    1, 0, 2065, 0, 1, 3, 2, 0, 0, 0);
    add("g_start",        1, 1, 0,    0, 0, 3, 0, 0, 0, 0);
    add("g_press_m2",     1, 0, 2057, 1, 1, 1, 1, 1, 1, 0);
    add("g_rel_m5",       1, 0, 2072, 0, 1, 2, 2, 2, 0, 0);
    add("m_start",        1, 1, 0,    0, 0, 2, 0, 0, 0, 0);
    add("m_miss_start",   1, 0, 2066, 0, 1, 3, 1, 0, 0, 0);
    add("m_press_ign",    1, 0, 2070, 1, 0, 3, 1, 0, 0, 0);
    add("m_release",      1, 0, 2077, 0, 0, 3, 1, 0, 0, 0);
    add("m_press_ign2",   1, 0, 2078, 1, 0, 3, 1, 0, 0, 0);
    add("m_orphan_p6",    1, 0, 2083, 0, 0, 3, 1, 0, 0, 0);
    add("m_orphan_miss",  1, 0, 2084, 0, 1, 3, 2, 0, 0, 0);
    add("d_start",        2, 1, 0,    0, 0, 3, 0, 0, 0, 0);
    add("d_note0",        2, 0, 10,   1, 1, 1, 1, 1, 0, 0);
    add("d_rel0",         2, 0, 11,   0, 0, 1, 1, 1, 0, 0);
    add("d_note1",        2, 0, 20,   1, 1, 1, 2, 2, 0, 0);
    add("d_rel1",         2, 0, 21,   0, 0, 1, 2, 2, 0, 0);
    add("d_note2",        2, 0, 30,   1, 1, 1, 3, 3, 0, 0);
    add("d_rel2",         2, 0, 31,   0, 0, 1, 3, 3, 0, 0);
    add("d_note3",        2, 0, 40,   1, 1, 1, 4, 4, 0, 0);
    add("d_done",         2, 0, 41,   0, 0, 1, 4, 4, 0, 1);
    add("d_done_hold",    2, 0, 60,   1, 0, 1, 4, 4, 0, 1);
    add("d_restart",      2, 1, 0,    0, 0, 1, 0, 0, 0, 0);
    add("x_start",        1, 1, 0,    0, 0, 1, 0, 0, 0, 0);
    add("x_press",        1, 0, 2060, 1, 1, 1, 1, 1, 1, 0);

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    exp_q.push_back(pack_exp(0, 2'd0, 8'd0, 10'd0, 0, 0));
    compare("reset_values");
    @(negedge Clk);
    Reset = 1'b0;

    foreach (vt[i]) apply(vt[i]);

    // Asynchronous reset in the middle of a hold
    @(negedge Clk);
    start    = 1'b0;
    key_down = 1'b1;
    song_time = 14'd2077;
    Reset    = 1'b1;
    #1;
    exp_q.push_back(pack_exp(0, 2'd0, 8'd0, 10'd0, 0, 0));
    compare("reset_mid_hold");
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, want %0d", dbg_state, IDLE);
    end
    @(posedge Clk);
    #1;
    exp_q.push_back(pack_exp(0, 2'd0, 8'd0, 10'd0, 0, 0));
    compare("reset_held_edge");
    @(negedge Clk);
    Reset = 1'b0;
    begin
      vec_t x;
      x.name = "idle_after_reset"; x.rom = 1; x.start = 0; x.st = 14'd2078;
      x.key = 0; x.v = 0; x.r = 2'd0; x.a = 8'd0; x.c = 10'd0; x.h = 0; x.d = 0;
      apply(x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_judge.md
Name: lane_judge

Overview:
- Per-lane judgement engine for the rhythm game; sits directly downstream of the lane chart ROM (J lane and its siblings).
- Drives the ROM read address and consumes the current note word at that address.
- Compares each note's frame timestamp with the running song frame count and the player's key edges.
- Emits per-note judgements (PERFECT/GOOD/MISS), hold status and a combo count to the score and render logic.

Parameters:
- PERFECT_WIN, 3, max |song_time − note_time| in frames for PERFECT.
- GOOD_WIN, 6, max |song_time − note_time| in frames for GOOD (≥ PERFECT_WIN).
- NUM_NOTES, 128, number of valid chart entries; the address never exceeds this.
- ADDR_W, 8, ROM address width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin or restart the song.
- song_time  in  14  current song frame count (60 Hz units), monotonic while running.
- key_down  in  1  lane key level, already synchronized to Clk.
- note_word  in  16  chart word at addr (ROM key_1): [15:14] type, [13:0] frame time.
- addr  out  ADDR_W  chart ROM read address.
- judge_valid  out  1  one-cycle pulse: judge_result is valid.
- judge_result  out  2  1 = PERFECT, 2 = GOOD, 3 = MISS.
- hold_active  out  1  high while a hold note is held.
- combo  out  10  current combo count.
- done  out  1  high once every note is consumed.

Behaviour:
- Reset (async): addr=0, combo=0, judge_valid=0, judge_result=0, hold_active=0, done=0, state=IDLE, key_q=0.
- Note types: 00 TAP, 01 HOLD_START, 10 HOLD_END, 11 reserved. A reserved word is treated as TAP.
- diff = song_time − note_time, computed as a 15-bit signed value. The window class comes from |diff|.
- press = key_down & ~key_q; release = ~key_down & key_q. key_q is registered every cycle.
- All judgement outputs are registered. An event detected in cycle N gives judge_valid and an addr increment in cycle N+1. At most one judgement per cycle.
- The ROM is combinational, so the new note_word is used in cycle N+1.
- IDLE: all outputs hold their values. start → RUN; addr=0, combo=0, done=0.
- RUN (head note TAP or HOLD_START):
  - press with |diff| ≤ GOOD_WIN: judge PERFECT if |diff| ≤ PERFECT_WIN, else GOOD. addr+1.
  - If that note is HOLD_START and was judged: go to HOLD and set hold_active=1.
  - diff > GOOD_WIN with no qualifying press: MISS, addr+1.
  - A press outside the window is ignored.
- RUN (head note HOLD_END, orphaned after a missed start): presses are ignored. When diff > GOOD_WIN: MISS, addr+1.
- HOLD (head note is HOLD_END):
  - release with |diff| ≤ GOOD_WIN: PERFECT or GOOD by window.
  - release with diff < −GOOD_WIN: MISS.
  - Still held once diff ≥ 0: PERFECT.
  - Every exit: addr+1, hold_active=0, → RUN.
- Combo: +1 on PERFECT or GOOD, saturating at 1023; cleared on MISS.
- When addr == NUM_NOTES in RUN: → DONE, done=1. addr is never incremented past NUM_NOTES.
- Simultaneous events:
  - start in any state wins over a same-cycle judgement: no judge_valid, state restarts.
  - A press in the same cycle the window expires still judges GOOD only if |diff| ≤ GOOD_WIN; otherwise MISS.
- DONE holds until start or Reset.
- Reset mid-song returns to IDLE immediately; no pending judgement is emitted.

Optional Feature:
- Macro: LANE_JUDGE_STATS_EN.
- Defined: adds outputs n_perfect, n_good, n_miss (10 bits each, saturating) and max_combo (10 bits). All four clear on Reset and on start.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Decomposition:
- rhythm_pkg:
  - judge_t enum (NONE=0, PERFECT, GOOD, MISS).
  - note type constants NOTE_TAP, NOTE_HOLD_START, NOTE_HOLD_END.
  - NOTE_TIME_W=14, NOTE_TYPE_MSB/LSB.
  - state enum {IDLE, RUN, HOLD, DONE}.
- Sub-module judge_window: combinational. Takes song_time and note_time; returns judge_t for an in-window hit, plus a late flag (diff > GOOD_WIN) and an early flag (diff < −GOOD_WIN).

Test Plan:
- TAP at time 50; press at song_time 51 → judge_valid next cycle with PERFECT, addr 0→1, combo 1.
- TAP at 50; press at 55 → GOOD. Second TAP at 83 with no press → MISS when song_time = 90, combo cleared to 0.
- HOLD_START 2059 / HOLD_END 2077; press at 2060, hold through 2077:
  - PERFECT at the start and hold_active=1;
  - PERFECT at 2077 and hold_active=0;
  - addr advances by 2 in total.
- Same hold, released at 2065 → start PERFECT, end MISS (diff −12), combo 0.
- Hold start missed (no press through 2066) → MISS. Later presses during the hold are ignored; the orphan HOLD_END gives MISS at 2084.
- NUM_NOTES=2: judge both notes → done=1, addr stays 2. start pulse → addr 0, done 0.
- Reset asserted mid-HOLD → all outputs at reset values in the same cycle, with no judge_valid.
